// File: rtl/enable_sequencer_pkg.sv
// Shared types and limits for the enable sequencer: FSM state encoding and
// channel-count bounds used to size the channel index.
package enable_sequencer_pkg;

  localparam int MIN_CHANNELS = 1;
  localparam int MAX_CHANNELS = 16;

  // Index must also represent N_CHANNELS itself ("all channels decided").
  localparam int IDX_W = $clog2(MAX_CHANNELS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    FIRE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sequencer_gap_counter.sv
// Gap counter for one inter-channel delay: loadable, saturating decrement,
// and a registered-value zero flag.
module sequencer_gap_counter #(
  parameter int DELAY_WIDTH = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic [DELAY_WIDTH-1:0] load_val_i,
  input  logic                   dec_i,
  output logic                   zero_o
);

  logic [DELAY_WIDTH-1:0] cnt_q;
  logic [DELAY_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DELAY_WIDTH'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/enable_sequencer_core.sv
// Turns each rising edge of the enable stream into an ordered burst of
// single-cycle channel pulses separated by per-channel gaps, flagging overruns.
module enable_sequencer_core
  import enable_sequencer_pkg::*;
#(
  parameter int N_CHANNELS  = 4,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              trigger_in,
  input  logic                              sequencer_enable,
  input  logic [N_CHANNELS*DELAY_WIDTH-1:0] delays,
  input  logic [N_CHANNELS-1:0]             channel_mask,
  input  logic                              clear_overrun,
  output logic [N_CHANNELS-1:0]             enable_out,
  output logic                              busy,
  output logic                              overrun_pulse,
  output logic                              overrun_flag
);

  seq_state_e             state_q;
  logic                   trig_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DELAY_WIDTH-1:0] dly_sh_q [N_CHANNELS];
  logic [N_CHANNELS-1:0]  mask_sh_q;
  logic [N_CHANNELS-1:0]  enable_out_q;
  logic                   busy_q;
  logic                   ovr_pulse_q;
  logic                   ovr_flag_q;

  logic                   edge_det;
  logic                   start;
  logic                   ovr_event;
  logic                   active;
  logic                   last_done;
  logic                   fire;
  logic [IDX_W-1:0]       next_idx;
  logic [DELAY_WIDTH-1:0] next_dly;
  logic                   cnt_load;
  logic [DELAY_WIDTH-1:0] cnt_load_val;
  logic                   cnt_dec;
  logic                   cnt_zero;

  assign edge_det  = trigger_in & ~trig_q;
  assign start     = edge_det & sequencer_enable & (state_q == IDLE);
  assign ovr_event = edge_det & sequencer_enable & busy_q;
  assign active    = (state_q != IDLE) & sequencer_enable;
  // idx_q == N_CHANNELS marks the cycle the last pulse is on the output.
  assign last_done = (idx_q == IDX_W'(N_CHANNELS));
  assign fire      = active & ~last_done & cnt_zero;
  assign next_idx  = idx_q + IDX_W'(1);

  always_comb begin
    next_dly = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (next_idx == IDX_W'(i)) begin
        next_dly = dly_sh_q[i];
      end
    end
  end

  // The first gap is loaded straight from the inputs on the accepted edge so
  // that a zero gap still fires channel 0 two cycles after the edge.
  assign cnt_load     = start | (fire & (next_idx != IDX_W'(N_CHANNELS)));
  assign cnt_load_val = start ? delays[DELAY_WIDTH-1:0] : next_dly;
  assign cnt_dec      = active & ~last_done & ~cnt_zero;

  sequencer_gap_counter #(
    .DELAY_WIDTH (DELAY_WIDTH)
  ) u_gap_counter (
    .clock_i    (clock),
    .reset_i    (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      trig_q       <= 1'b1;
      idx_q        <= '0;
      mask_sh_q    <= '0;
      enable_out_q <= '0;
      busy_q       <= 1'b0;
      ovr_pulse_q  <= 1'b0;
      ovr_flag_q   <= 1'b0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        dly_sh_q[i] <= '0;
      end
    end else begin
      trig_q       <= trigger_in;
      ovr_pulse_q  <= ovr_event;
      enable_out_q <= '0;

      // A new overrun beats a simultaneous clear.
      if (ovr_event) begin
        ovr_flag_q <= 1'b1;
      end else if (clear_overrun) begin
        ovr_flag_q <= 1'b0;
      end

      if (start) begin
        state_q   <= LOAD;
        busy_q    <= 1'b1;
        idx_q     <= '0;
        mask_sh_q <= channel_mask;
        for (int i = 0; i < N_CHANNELS; i++) begin
          dly_sh_q[i] <= delays[i*DELAY_WIDTH +: DELAY_WIDTH];
        end
      end else if (state_q != IDLE) begin
        if (!sequencer_enable || last_done) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else if (fire) begin
          state_q <= FIRE;
          idx_q   <= next_idx;
          for (int i = 0; i < N_CHANNELS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              enable_out_q[i] <= mask_sh_q[i];
            end
          end
        end else begin
          state_q <= WAIT;
        end
      end
    end
  end

  assign enable_out    = enable_out_q;
  assign busy          = busy_q;
  assign overrun_pulse = ovr_pulse_q;
  assign overrun_flag  = ovr_flag_q;

endmodule

// File: tb/tb_enable_sequencer_core.sv
// Directed bench for enable_sequencer_core: burst timing, gaps, masking,
// input latching, overrun, abort, reset and periodic triggering.
module tb_enable_sequencer_core;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          trigger_in = 1'b0;
  logic          sequencer_enable = 1'b1;
  logic [N*DW-1:0] delays = '0;
  logic [N-1:0]  channel_mask = '1;
  logic          clear_overrun = 1'b0;
  logic [N-1:0]  enable_out;
  logic          busy;
  logic          overrun_pulse;
  logic          overrun_flag;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;

  logic [3:0] en_log   [0:63];
  logic       busy_log [0:63];
  logic       op_log   [0:63];
  logic       of_log   [0:63];
  int         pulse_cnt [4];
  int         op_cnt;
  int         multi_cnt;

  always #5 clock = ~clock;

  enable_sequencer_core #(
    .N_CHANNELS  (N),
    .DELAY_WIDTH (DW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .trigger_in       (trigger_in),
    .sequencer_enable (sequencer_enable),
    .delays           (delays),
    .channel_mask     (channel_mask),
    .clear_overrun    (clear_overrun),
    .enable_out       (enable_out),
    .busy             (busy),
    .overrun_pulse    (overrun_pulse),
    .overrun_flag     (overrun_flag)
  );

  task automatic tick();
    @(posedge clock);
    #1;
    t++;
    if (t < 64) begin
      en_log[t]   = enable_out;
      busy_log[t] = busy;
      op_log[t]   = overrun_pulse;
      of_log[t]   = overrun_flag;
    end
    for (int k = 0; k < 4; k++) if (enable_out[k]) pulse_cnt[k]++;
    if (overrun_pulse) op_cnt++;
    if ($countones(enable_out) > 1) multi_cnt++;
  endtask

  task automatic idle(input int n);
    trigger_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    delays = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    trigger_in = 1'b0;
    repeat (3) tick();
    n_checks++; if (enable_out !== 4'b0) $display("FAIL reset_en got %b want 0000", enable_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (overrun_pulse !== 1'b0) $display("FAIL reset_op got %b want 0", overrun_pulse); else n_pass++;
    n_checks++; if (overrun_flag !== 1'b0) $display("FAIL reset_of got %b want 0", overrun_flag); else n_pass++;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    int p[4];
    p = '{2, 3, 4, 5};
    idle(3);
    set_delays(0, 0, 0, 0);
    channel_mask = 4'hF;
    t = 0; trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    repeat (7) tick();
    for (int c = 1; c <= 8; c++) begin
      logic [3:0] ee;
      logic eb;
      ee = 4'b0;
      for (int k = 0; k < 4; k++) if (p[k] == c) ee[k] = 1'b1;
      eb = (c <= p[3]);
      n_checks++; if (en_log[c] !== ee) $display("FAIL basic_en t=%0d got %b want %b", c, en_log[c], ee); else n_pass++;
      n_checks++; if (busy_log[c] !== eb) $display("FAIL basic_busy t=%0d got %b want %b", c, busy_log[c], eb); else n_pass++;
    end
  endtask

  task automatic test_gaps();
    int p[4];
    p = '{5, 6, 17, 19};
    idle(3);
    set_delays(3, 0, 10, 1);
    channel_mask = 4'hF;
    t = 0; trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    while (t < 22) tick();
    for (int c = 1; c <= 22; c++) begin
      logic [3:0] ee;
      logic eb;
      ee = 4'b0;
      for (int k = 0; k < 4; k++) if (p[k] == c) ee[k] = 1'b1;
      eb = (c <= 19);
      n_checks++; if (en_log[c] !== ee) $display("FAIL gaps_en t=%0d got %b want %b", c, en_log[c], ee); else n_pass++;
      n_checks++; if (busy_log[c] !== eb) $display("FAIL gaps_busy t=%0d got %b want %b", c, busy_log[c], eb); else n_pass++;
    end
  endtask

  task automatic test_mask();
    int p[4];
    logic [3:0] m;
    p = '{3, 6, 10, 11};
    m = 4'b0101;
    idle(3);
    set_delays(1, 2, 3, 0);
    channel_mask = m;
    t = 0; trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    while (t < 14) tick();
    for (int c = 1; c <= 14; c++) begin
      logic [3:0] ee;
      logic eb;
      ee = 4'b0;
      for (int k = 0; k < 4; k++) if (p[k] == c && m[k]) ee[k] = 1'b1;
      eb = (c <= 11);
      n_checks++; if (en_log[c] !== ee) $display("FAIL mask_en t=%0d got %b want %b", c, en_log[c], ee); else n_pass++;
      n_checks++; if (busy_log[c] !== eb) $display("FAIL mask_busy t=%0d got %b want %b", c, busy_log[c], eb); else n_pass++;
    end
    channel_mask = 4'hF;
  endtask

  task automatic test_latch();
    int p[4];
    p = '{4, 7, 10, 13};
    idle(3);
    set_delays(2, 2, 2, 2);
    channel_mask = 4'hF;
    t = 0; trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    while (t < 3) tick();
    set_delays(0, 0, 0, 0);
    channel_mask = 4'h0;
    while (t < 16) tick();
    for (int c = 1; c <= 16; c++) begin
      logic [3:0] ee;
      logic eb;
      ee = 4'b0;
      for (int k = 0; k < 4; k++) if (p[k] == c) ee[k] = 1'b1;
      eb = (c <= 13);
      n_checks++; if (en_log[c] !== ee) $display("FAIL latch_en t=%0d got %b want %b", c, en_log[c], ee); else n_pass++;
      n_checks++; if (busy_log[c] !== eb) $display("FAIL latch_busy t=%0d got %b want %b", c, busy_log[c], eb); else n_pass++;
    end
    channel_mask = 4'hF;
  endtask

  task automatic test_overrun();
    int p[4];
    p = '{5, 6, 17, 19};
    idle(3);
    set_delays(3, 0, 10, 1);
    channel_mask = 4'hF;
    t = 0; trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    while (t < 8) tick();
    trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    while (t < 22) tick();
    for (int c = 1; c <= 22; c++) begin
      logic [3:0] ee;
      ee = 4'b0;
      for (int k = 0; k < 4; k++) if (p[k] == c) ee[k] = 1'b1;
      n_checks++; if (en_log[c] !== ee) $display("FAIL ovr_en t=%0d got %b want %b", c, en_log[c], ee); else n_pass++;
      n_checks++; if (op_log[c] !== (c == 9)) $display("FAIL ovr_pulse t=%0d got %b want %b", c, op_log[c], (c == 9)); else n_pass++;
      n_checks++; if (of_log[c] !== (c >= 9)) $display("FAIL ovr_flag t=%0d got %b want %b", c, of_log[c], (c >= 9)); else n_pass++;
    end
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
    n_checks++; if (overrun_flag !== 1'b0) $display("FAIL ovr_clear got %b want 0", overrun_flag); else n_pass++;

    idle(3);
    t = 0; trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    while (t < 3) tick();
    trigger_in = 1'b1; clear_overrun = 1'b1; tick();
    trigger_in = 1'b0; clear_overrun = 1'b0;
    n_checks++; if (overrun_pulse !== 1'b1) $display("FAIL setwins_pulse got %b want 1", overrun_pulse); else n_pass++;
    n_checks++; if (overrun_flag !== 1'b1) $display("FAIL setwins_flag got %b want 1", overrun_flag); else n_pass++;
    tick();
    n_checks++; if (overrun_pulse !== 1'b0) $display("FAIL setwins_pulse_end got %b want 0", overrun_pulse); else n_pass++;
    n_checks++; if (overrun_flag !== 1'b1) $display("FAIL setwins_sticky got %b want 1", overrun_flag); else n_pass++;
    idle(25);
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
  endtask

  task automatic test_edge_boundary();
    idle(3);
    set_delays(0, 0, 0, 0);
    t = 0; trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    while (t < 5) tick();
    trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    n_checks++; if (en_log[5] !== 4'b1000) $display("FAIL bnd_last_en got %b want 1000", en_log[5]); else n_pass++;
    n_checks++; if (overrun_pulse !== 1'b1) $display("FAIL bnd_same_ovr got %b want 1", overrun_pulse); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL bnd_same_busy got %b want 0", busy); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL bnd_same_noburst got %b want 0", busy); else n_pass++;

    idle(3);
    t = 0; trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    while (t < 6) tick();
    trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL bnd_next_busy got %b want 1", busy); else n_pass++;
    n_checks++; if (overrun_pulse !== 1'b0) $display("FAIL bnd_next_ovr got %b want 0", overrun_pulse); else n_pass++;
    tick();
    n_checks++; if (enable_out !== 4'b0001) $display("FAIL bnd_next_en got %b want 0001", enable_out); else n_pass++;
    idle(10);
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
  endtask

  task automatic test_disabled_edge();
    idle(3);
    set_delays(0, 0, 0, 0);
    sequencer_enable = 1'b0;
    t = 0; trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    repeat (5) tick();
    for (int c = 1; c <= 6; c++) begin
      n_checks++; if (busy_log[c] !== 1'b0) $display("FAIL dis_busy t=%0d got %b want 0", c, busy_log[c]); else n_pass++;
      n_checks++; if (op_log[c] !== 1'b0) $display("FAIL dis_ovr t=%0d got %b want 0", c, op_log[c]); else n_pass++;
      n_checks++; if (en_log[c] !== 4'b0) $display("FAIL dis_en t=%0d got %b want 0000", c, en_log[c]); else n_pass++;
    end
    sequencer_enable = 1'b1;
  endtask

  task automatic test_abort();
    idle(3);
    set_delays(0, 0, 5, 5);
    t = 0; trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    while (t < 4) tick();
    sequencer_enable = 1'b0;
    while (t < 18) tick();
    n_checks++; if (en_log[2] !== 4'b0001) $display("FAIL abort_ch0 got %b want 0001", en_log[2]); else n_pass++;
    n_checks++; if (en_log[3] !== 4'b0010) $display("FAIL abort_ch1 got %b want 0010", en_log[3]); else n_pass++;
    n_checks++; if (busy_log[4] !== 1'b1) $display("FAIL abort_busy4 got %b want 1", busy_log[4]); else n_pass++;
    for (int c = 5; c <= 18; c++) begin
      n_checks++; if (busy_log[c] !== 1'b0) $display("FAIL abort_busy t=%0d got %b want 0", c, busy_log[c]); else n_pass++;
      n_checks++; if (en_log[c] !== 4'b0) $display("FAIL abort_en t=%0d got %b want 0000", c, en_log[c]); else n_pass++;
    end
    sequencer_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    idle(3);
    set_delays(0, 0, 0, 0);
    t = 0; trigger_in = 1'b1; tick(); trigger_in = 1'b0;
    tick();
    reset = 1'b1; trigger_in = 1'b1;
    tick(); tick();
    reset = 1'b0;
    while (t < 10) tick();
    for (int c = 3; c <= 10; c++) begin
      n_checks++; if (en_log[c] !== 4'b0) $display("FAIL rmid_en t=%0d got %b want 0000", c, en_log[c]); else n_pass++;
      n_checks++; if (busy_log[c] !== 1'b0) $display("FAIL rmid_busy t=%0d got %b want 0", c, busy_log[c]); else n_pass++;
      n_checks++; if (op_log[c] !== 1'b0) $display("FAIL rmid_ovr t=%0d got %b want 0", c, op_log[c]); else n_pass++;
    end
    trigger_in = 1'b0; tick();
    trigger_in = 1'b1; tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL rmid_rearm got %b want 1", busy); else n_pass++;
    idle(10);
  endtask

  task automatic test_periodic(input int period, input int n_edges, input int exp_bursts, input int exp_ovr);
    idle(3);
    set_delays(5, 5, 5, 5);
    channel_mask = 4'hF;
    for (int k = 0; k < 4; k++) pulse_cnt[k] = 0;
    op_cnt = 0;
    multi_cnt = 0;
    for (int e = 0; e < n_edges; e++) begin
      trigger_in = 1'b1; tick(); trigger_in = 1'b0;
      repeat (period - 1) tick();
    end
    repeat (30) tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (pulse_cnt[k] !== exp_bursts)
        $display("FAIL periodic%0d_ch%0d pulses got %0d want %0d", period, k, pulse_cnt[k], exp_bursts);
      else n_pass++;
    end
    n_checks++; if (op_cnt !== exp_ovr) $display("FAIL periodic%0d_ovr got %0d want %0d", period, op_cnt, exp_ovr); else n_pass++;
    n_checks++; if (multi_cnt !== 0) $display("FAIL periodic%0d_onehot got %0d want 0", period, multi_cnt); else n_pass++;
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_mask();
    test_latch();
    test_overrun();
    test_edge_boundary();
    test_disabled_edge();
    test_abort();
    test_reset_mid();
    test_periodic(50, 4, 4, 0);
    test_periodic(20, 5, 3, 2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
